// File: rtl/apb3_fabric_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb3_fabric_pkg
//  Description : Shared types, constants and helpers for the registered APB3
//                fabric with slot decode and PREADY watchdog.
//                Contents:
//                  fsm_state_e  - fabric FSM encoding (IDLE/SETUP/ACCESS/RESP)
//                  SLOT_W       - width of the slot field inside PADDR
//                  slot_mapped  - 1 when a slot number is populated and enabled
//  Revision    : 1.0 - initial release
// ============================================================================
package apb3_fabric_pkg;

    localparam int SLOT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } fsm_state_e;

    // A slot is reachable only when it exists in this build and is enabled.
    function automatic logic slot_mapped(input logic [SLOT_W-1:0] slot,
                                         input int                nslaves,
                                         input logic [15:0]       slot_en);
        return (int'(slot) < nslaves) && slot_en[slot];
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb3_slot_decode.sv
`default_nettype none
// ============================================================================
//  Module      : apb3_slot_decode
//  Description : Combinational slot decoder. Turns the 4-bit slot field of the
//                master address into a one-hot slave select plus a "mapped"
//                flag. Unmapped or disabled slots produce an all-zero select.
//  Ports       : slot    in  SLOT_W    slot field, PADDR[SLOT_LSB+3:SLOT_LSB]
//                sel     out NSLAVES   one-hot select (0 when unmapped)
//                mapped  out 1         slot exists and is enabled
//  Revision    : 1.0 - initial release
// ============================================================================
module apb3_slot_decode
    import apb3_fabric_pkg::*;
#(
    parameter int          NSLAVES = 4,
    parameter logic [15:0] SLOT_EN = 16'hFFFF
)(
    input  logic [SLOT_W-1:0]  slot,
    output logic [NSLAVES-1:0] sel,
    output logic               mapped
);

    assign mapped = slot_mapped(slot, NSLAVES, SLOT_EN);

    generate
        for (genvar k = 0; k < NSLAVES; k++) begin : g_sel
            assign sel[k] = mapped && (slot == SLOT_W'(k));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb3_fabric_wdt.sv
`default_nettype none
// ============================================================================
//  Module      : apb3_fabric_wdt
//  Description : Registered APB3 interconnect, one master to NSLAVES slots.
//                Adds a per-slot enable mask, a decode-error response for
//                unmapped/disabled slots and a PREADY watchdog that aborts a
//                hung slave with PSLVERR.
//  Ports       : PCLK/PRESET            clock, synchronous active-high reset
//                PSEL/PENABLE/PWRITE/
//                PADDR/PWDATA           master request
//                PRDATA/PREADY/PSLVERR  master response (0 unless PREADY)
//                PSELS/PENABLES/PWRITES/
//                PADDRS/PWDATAS         registered slave request
//                PRDATAS/PREADYS/
//                PSLVERRS               slave responses, slot k at bit/lane k
//                err_decode             1-cycle pulse on unmapped access
//                err_timeout            1-cycle pulse on watchdog abort
//  Revision    : 1.0 - initial release
// ============================================================================
module apb3_fabric_wdt
    import apb3_fabric_pkg::*;
#(
    parameter int          NSLAVES  = 4,
    parameter int          AWIDTH   = 32,
    parameter int          DWIDTH   = 32,
    parameter int          SLOT_LSB = 12,
    parameter logic [15:0] SLOT_EN  = 16'hFFFF,
    parameter int          TIMEOUT  = 256
)(
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [AWIDTH-1:0]         PADDR,
    input  logic [DWIDTH-1:0]         PWDATA,
    output logic [DWIDTH-1:0]         PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [NSLAVES-1:0]        PSELS,
    output logic                      PENABLES,
    output logic                      PWRITES,
    output logic [AWIDTH-1:0]         PADDRS,
    output logic [DWIDTH-1:0]         PWDATAS,
    input  logic [NSLAVES*DWIDTH-1:0] PRDATAS,
    input  logic [NSLAVES-1:0]        PREADYS,
    input  logic [NSLAVES-1:0]        PSLVERRS,
    output logic                      err_decode,
    output logic                      err_timeout
);

    localparam logic [1:0] c_ST_IDLE   = ST_IDLE;
    localparam logic [1:0] c_ST_SETUP  = ST_SETUP;
    localparam logic [1:0] c_ST_ACCESS = ST_ACCESS;
    localparam logic [1:0] c_ST_RESP   = ST_RESP;

    // Keep at least one bit so the TIMEOUT=0 build still elaborates.
    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [1:0]         r_state;
    logic [NSLAVES-1:0] r_sel;
    logic               r_mapped;
    logic [AWIDTH-1:0]  r_addr;
    logic [DWIDTH-1:0]  r_wdata;
    logic               r_write;
    logic [DWIDTH-1:0]  r_rdata;
    logic               r_slverr;
    logic               r_err_decode;
    logic               r_err_timeout;
    logic [c_CNT_W-1:0] r_cnt;

    logic [NSLAVES-1:0] w_dec_sel;
    logic               w_dec_mapped;
    logic [DWIDTH-1:0]  w_slv_rdata;
    logic               w_slv_ready;
    logic               w_slv_err;
    logic               w_timeout;

    apb3_slot_decode #(
        .NSLAVES (NSLAVES),
        .SLOT_EN (SLOT_EN)
    ) u_decode (
        .slot   (PADDR[SLOT_LSB +: SLOT_W]),
        .sel    (w_dec_sel),
        .mapped (w_dec_mapped)
    );

    // Only the selected slot's response lanes are looked at; r_sel is
    // one-hot (or zero), so an OR-reduction acts as the mux.
    always_comb begin
        w_slv_rdata = '0;
        for (int k = 0; k < NSLAVES; k++) begin
            if (r_sel[k]) begin
                w_slv_rdata = w_slv_rdata | PRDATAS[k*DWIDTH +: DWIDTH];
            end
        end
    end

    assign w_slv_ready = |(PREADYS  & r_sel);
    assign w_slv_err   = |(PSLVERRS & r_sel);

    generate
        if (TIMEOUT != 0) begin : g_wdt_on
            localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
            assign w_timeout = (r_cnt == c_CNT_LAST);
        end else begin : g_wdt_off
            assign w_timeout = 1'b0;
        end
    endgenerate

    // The decode result is registered at the IDLE edge, so a decode error
    // also passes through the SETUP cycle (with no slave selected) before
    // answering the master.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state       <= c_ST_IDLE;
            r_sel         <= '0;
            r_mapped      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_write       <= 1'b0;
            r_rdata       <= '0;
            r_slverr      <= 1'b0;
            r_err_decode  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_err_decode  <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        r_addr   <= PADDR;
                        r_wdata  <= PWDATA;
                        r_write  <= PWRITE;
                        r_sel    <= w_dec_sel;
                        r_mapped <= w_dec_mapped;
                        r_state  <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    if (r_mapped) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_ACCESS;
                    end else begin
                        r_rdata      <= '0;
                        r_slverr     <= 1'b1;
                        r_err_decode <= 1'b1;
                        r_state      <= c_ST_RESP;
                    end
                end
                c_ST_ACCESS: begin
                    // A slave answering in the last allowed cycle beats the watchdog.
                    if (w_slv_ready) begin
                        r_rdata  <= w_slv_rdata;
                        r_slverr <= w_slv_err;
                        r_state  <= c_ST_RESP;
                    end else if (w_timeout) begin
                        r_rdata       <= '0;
                        r_slverr      <= 1'b1;
                        r_err_timeout <= 1'b1;
                        r_state       <= c_ST_RESP;
                    end else if (r_cnt != {c_CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_RESP: begin
                    // Completes on the master's ACCESS beat, or drops on a master abort.
                    if (!PSEL || PENABLE) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign PSELS       = ((r_state == c_ST_SETUP) || (r_state == c_ST_ACCESS)) ? r_sel : '0;
    assign PENABLES    = (r_state == c_ST_ACCESS);
    assign PWRITES     = r_write;
    assign PADDRS      = r_addr;
    assign PWDATAS     = r_wdata;
    assign PREADY      = (r_state == c_ST_RESP) && PSEL && PENABLE;
    assign PRDATA      = PREADY ? r_rdata  : '0;
    assign PSLVERR     = PREADY ? r_slverr : 1'b0;
    assign err_decode  = r_err_decode;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb3_fabric_wdt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb3_fabric_wdt
//  Description : Directed self-checking bench for apb3_fabric_wdt, built with
//                4 slots, slot 3 disabled (SLOT_EN=0x0007) and TIMEOUT=8.
//                Unselected slots always drive PREADYS/PSLVERRS high so any
//                leak from them shows up in the results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb3_fabric_wdt;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic              PSEL = 1'b0;
    logic              PENABLE = 1'b0;
    logic              PWRITE = 1'b0;
    logic [AW-1:0]     PADDR = '0;
    logic [DW-1:0]     PWDATA = '0;
    logic [DW-1:0]     PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [NS-1:0]     PSELS;
    logic              PENABLES;
    logic              PWRITES;
    logic [AW-1:0]     PADDRS;
    logic [DW-1:0]     PWDATAS;
    logic [NS*DW-1:0]  PRDATAS = '0;
    logic [NS-1:0]     PREADYS = '0;
    logic [NS-1:0]     PSLVERRS = '0;
    logic              err_decode;
    logic              err_timeout;

    apb3_fabric_wdt #(
        .NSLAVES  (NS),
        .AWIDTH   (AW),
        .DWIDTH   (DW),
        .SLOT_LSB (12),
        .SLOT_EN  (16'h0007),
        .TIMEOUT  (8)
    ) u_dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .PSELS       (PSELS),
        .PENABLES    (PENABLES),
        .PWRITES     (PWRITES),
        .PADDRS      (PADDRS),
        .PWDATAS     (PWDATAS),
        .PRDATAS     (PRDATAS),
        .PREADYS     (PREADYS),
        .PSLVERRS    (PSLVERRS),
        .err_decode  (err_decode),
        .err_timeout (err_timeout)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_errors = 0;

    // Results of the last transfer
    int            res_lat;
    int            res_acc;
    int            res_dec;
    int            res_tmo;
    logic [DW-1:0] res_rdata;
    logic          res_err;
    logic [NS-1:0] res_sel;
    logic [AW-1:0] res_addr;
    logic [DW-1:0] res_wdata;
    logic          res_write;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One master transfer starting with SETUP in the next clock cycle (cycle 0).
    // The slave in slot exp_sel answers after 'waits' ACCESS wait states, or
    // never when hang=1. res_lat is the cycle PREADY was seen, -1 if never.
    task automatic apb_xfer(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic write, input logic [NS-1:0] exp_sel,
                            input int waits, input logic hang, input logic slverr);
        logic rdy;
        res_lat = -1; res_acc = 0; res_dec = 0; res_tmo = 0;
        res_rdata = '0; res_err = 1'b0; res_sel = '0;
        res_addr = '0; res_wdata = '0; res_write = 1'b0;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = wdata; PWRITE = write;
        PREADYS = ~exp_sel; PSLVERRS = ~exp_sel;
        @(negedge PCLK);
        for (int c = 1; c <= 40 && res_lat < 0; c++) begin
            @(posedge PCLK); #1;
            PENABLE = 1'b1;
            if (PENABLES) res_acc++;
            rdy = PENABLES && !hang && (res_acc > waits);
            PREADYS  = ~exp_sel | (rdy ? exp_sel : '0);
            PSLVERRS = ~exp_sel | ((rdy && slverr) ? exp_sel : '0);
            @(negedge PCLK);
            if (c == 1) begin
                res_sel = PSELS; res_addr = PADDRS; res_wdata = PWDATAS; res_write = PWRITES;
            end
            if (err_decode)  res_dec++;
            if (err_timeout) res_tmo++;
            if (PREADY) begin
                res_lat = c; res_rdata = PRDATA; res_err = PSLVERR;
            end
        end
        PSEL = 1'b0; PENABLE = 1'b0; PREADYS = '0; PSLVERRS = '0;
    endtask

    initial begin
        PRDATAS = {32'h3333_3333, 32'h1234_5678, 32'h1111_1111, 32'hA5A5_0000};

        // Reset state
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check_eq("rst_psels",   32'(PSELS), 32'h0);
        check_eq("rst_pready",  32'(PREADY), 32'h0);
        check_eq("rst_paddrs",  PADDRS, 32'h0);
        check_eq("rst_errs",    32'({err_decode, err_timeout, PENABLES, PWRITES}), 32'h0);
        #1 PRESET = 1'b0;

        // 1: write slot 1, zero-wait slave
        apb_xfer(32'h0000_1004, 32'hDEAD_BEEF, 1'b1, 4'b0010, 0, 1'b0, 1'b0);
        check_eq("t1_lat",    32'(res_lat), 32'd3);
        check_eq("t1_psels",  32'(res_sel), 32'h2);
        check_eq("t1_pwdata", res_wdata, 32'hDEAD_BEEF);
        check_eq("t1_paddr",  res_addr, 32'h0000_1004);
        check_eq("t1_pwrite", 32'(res_write), 32'h1);
        check_eq("t1_err",    32'(res_err), 32'h0);
        check_eq("t1_pulses", 32'(res_dec + res_tmo), 32'h0);

        // 2: back-to-back read of slot 2 with 5 wait states
        apb_xfer(32'h0000_2010, 32'h0, 1'b0, 4'b0100, 5, 1'b0, 1'b0);
        check_eq("t2_lat",    32'(res_lat), 32'd8);
        check_eq("t2_rdata",  res_rdata, 32'h1234_5678);
        check_eq("t2_err",    32'(res_err), 32'h0);
        check_eq("t2_pwrite", 32'(res_write), 32'h0);

        // 3: slot 5 does not exist
        apb_xfer(32'h0000_5000, 32'h0, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
        check_eq("t3_lat",   32'(res_lat), 32'd2);
        check_eq("t3_psels", 32'(res_sel), 32'h0);
        check_eq("t3_err",   32'(res_err), 32'h1);
        check_eq("t3_dec",   32'(res_dec), 32'd1);
        check_eq("t3_rdata", res_rdata, 32'h0);

        // 3b: slot 3 exists but is disabled by the mask
        apb_xfer(32'h0000_3000, 32'h0, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
        check_eq("t3b_lat", 32'(res_lat), 32'd2);
        check_eq("t3b_err", 32'(res_err), 32'h1);
        check_eq("t3b_dec", 32'(res_dec), 32'd1);

        // 4: slot 0 never ready, watchdog aborts after 8 ACCESS cycles
        apb_xfer(32'h0000_0020, 32'h0, 1'b0, 4'b0001, 0, 1'b1, 1'b0);
        check_eq("t4_acc",   32'(res_acc), 32'd8);
        check_eq("t4_lat",   32'(res_lat), 32'd10);
        check_eq("t4_err",   32'(res_err), 32'h1);
        check_eq("t4_tmo",   32'(res_tmo), 32'd1);
        check_eq("t4_dec",   32'(res_dec), 32'd0);
        check_eq("t4_rdata", res_rdata, 32'h0);

        // 4b: ready in the last allowed ACCESS cycle wins over the watchdog
        apb_xfer(32'h0000_1000, 32'h0, 1'b0, 4'b0010, 7, 1'b0, 1'b0);
        check_eq("t4b_lat",   32'(res_lat), 32'd10);
        check_eq("t4b_rdata", res_rdata, 32'h1111_1111);
        check_eq("t4b_err",   32'(res_err), 32'h0);
        check_eq("t4b_tmo",   32'(res_tmo), 32'd0);

        // 5: reset while in ACCESS
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0000_0044; PWDATA = 32'hCAFE_F00D; PWRITE = 1'b1;
        PREADYS = 4'b1110; PSLVERRS = 4'b1110;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        check_eq("t5_in_access", 32'({PENABLES, PSELS}), 32'h11);
        @(posedge PCLK); #1 PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PREADYS = '0; PSLVERRS = '0;
        @(negedge PCLK);
        check_eq("t5_psels",  32'({PENABLES, PSELS}), 32'h0);
        check_eq("t5_paddrs", PADDRS, 32'h0);
        check_eq("t5_pwdata", PWDATAS, 32'h0);
        check_eq("t5_resp",   32'({PREADY, PSLVERR, PWRITES, err_decode, err_timeout}), 32'h0);
        apb_xfer(32'h0000_2000, 32'h0, 1'b0, 4'b0100, 0, 1'b0, 1'b0);
        check_eq("t5_next_lat",   32'(res_lat), 32'd3);
        check_eq("t5_next_rdata", res_rdata, 32'h1234_5678);

        // 6: slave error response
        apb_xfer(32'h0000_0008, 32'h0, 1'b0, 4'b0001, 1, 1'b0, 1'b1);
        check_eq("t6_lat",    32'(res_lat), 32'd4);
        check_eq("t6_err",    32'(res_err), 32'h1);
        check_eq("t6_rdata",  res_rdata, 32'hA5A5_0000);
        check_eq("t6_pulses", 32'(res_dec + res_tmo), 32'h0);

        repeat (2) @(posedge PCLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
